// File: rtl/prg_uploader.sv
// rtl/prg_uploader.sv - streams a stored BASIC program out of memory; PRG_UPLOADER_HEADER_EN adds a load-address header
module prg_uploader #(
  parameter logic [24:0] PRG_START_ADDR = 25'h5608,
  parameter logic [24:0] PTR_PROGND     = 25'h55e4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        rd,
  output logic [24:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  localparam logic [15:0] START16     = PRG_START_ADDR[15:0];
  localparam logic [8:0]  START_BANK  = PRG_START_ADDR[24:16];
  localparam logic [24:0] PTR_HI_ADDR = PTR_PROGND + 25'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_PTR_LO, S_PTR_HI, S_CHECK, S_FETCH, S_SEND, S_FINISH
  } state_t;

  state_t      state_q;
  logic [1:0]  rst_sync_q;
  logic        rst_int_n;
  logic        busy_q, rd_q, pend_q, out_valid_q, done_q;
  logic [24:0] addr_q;
  logic [7:0]  out_data_q, ptr_lo_q;
  logic [15:0] end_q, len_q, cnt_q;
  logic [15:0] cnt_d, len_d;
  logic [24:0] next_addr_d;
  logic        empty_d, capture_d;
`ifdef PRG_UPLOADER_HEADER_EN
  logic [1:0]  hdr_left_q;
`endif

  // Reset assertion reaches the FSM at once; release is delayed by two clk edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Byte arithmetic shared by the FSM: length, next counter value, next fetch address
  always_comb begin
    cnt_d       = cnt_q + 16'd1;
    len_d       = end_q - START16;
    empty_d     = (end_q <= START16);
    next_addr_d = {START_BANK, START16 + cnt_d};
    capture_d   = ena && pend_q;
  end

  // Upload sequencer: pointer read, length check, fetch/send loop, done pulse
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      out_data_q  <= '0;
      ptr_lo_q    <= '0;
      end_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
`ifdef PRG_UPLOADER_HEADER_EN
      hdr_left_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        rd_q        <= 1'b0;
        pend_q      <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        // The read request occupies exactly one ena slot; data follows on the next one
        if (ena && rd_q) begin
          rd_q   <= 1'b0;
          pend_q <= 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_PTR_LO;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
              addr_q  <= PTR_PROGND;
              cnt_q   <= '0;
              len_q   <= '0;
            end
          end
          S_PTR_LO: begin
            if (capture_d) begin
              pend_q   <= 1'b0;
              ptr_lo_q <= data_in;
              rd_q     <= 1'b1;
              addr_q   <= PTR_HI_ADDR;
              state_q  <= S_PTR_HI;
            end
          end
          S_PTR_HI: begin
            if (capture_d) begin
              pend_q  <= 1'b0;
              end_q   <= {data_in, ptr_lo_q};
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            len_q <= empty_d ? 16'd0 : len_d;
`ifdef PRG_UPLOADER_HEADER_EN
            // Header bytes go out before any program fetch, even for an empty program
            out_data_q  <= START16[7:0];
            out_valid_q <= 1'b1;
            hdr_left_q  <= 2'd2;
            state_q     <= S_SEND;
`else
            if (empty_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              rd_q    <= 1'b1;
              addr_q  <= {START_BANK, START16};
              state_q <= S_FETCH;
            end
`endif
          end
          S_FETCH: begin
            if (capture_d) begin
              pend_q      <= 1'b0;
              out_data_q  <= data_in;
              out_valid_q <= 1'b1;
              state_q     <= S_SEND;
            end
          end
          S_SEND: begin
            if (out_ready) begin
`ifdef PRG_UPLOADER_HEADER_EN
              if (hdr_left_q == 2'd2) begin
                out_data_q <= START16[15:8];
                hdr_left_q <= 2'd1;
              end else if (hdr_left_q == 2'd1) begin
                hdr_left_q  <= 2'd0;
                out_valid_q <= 1'b0;
                if (len_q == 16'd0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
                end else begin
                  rd_q    <= 1'b1;
                  addr_q  <= {START_BANK, START16};
                  state_q <= S_FETCH;
                end
              end else begin
`else
              begin
`endif
                out_valid_q <= 1'b0;
                cnt_q       <= cnt_d;
                if (cnt_d == len_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
                end else begin
                  rd_q    <= 1'b1;
                  addr_q  <= next_addr_d;
                  state_q <= S_FETCH;
                end
              end
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign rd        = rd_q;
  assign addr      = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prg_uploader.sv
// tb/tb_prg_uploader.sv - randomized self-checking bench for prg_uploader
`timescale 1ns/1ps
module tb_prg_uploader;

  localparam logic [24:0] START = 25'h5608;
  localparam logic [24:0] PTR   = 25'h55e4;
  localparam int START16 = 'h5608;
  localparam int PTR16   = 'h55e4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ena = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        busy, rd, out_valid, done;
  logic [24:0] addr;
  logic [7:0]  out_data;

  prg_uploader #(.PRG_START_ADDR(START), .PTR_PROGND(PTR)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .start(start), .abort(abort),
    .busy(busy), .rd(rd), .addr(addr), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  int          ena_pct = 100;
  int          ready_pct = 100;
  int          stall_idx = -1;
  int          stall_left = 0;
  logic [7:0]  stream_q[$];
  logic [24:0] rd_log[$];
  logic [7:0]  exp_q[$];
  logic [24:0] exp_addr_q[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_xfer_cyc = -1;
  int          done_cyc = -1;
  logic        resp_pend = 1'b0;
  logic [15:0] resp_addr = 16'h0;

  // Memory slot model, sink and event log; everything decided on the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (resp_pend) begin
      data_in   = mem[resp_addr];
      resp_pend = 1'b0;
    end
    ena = (int'($urandom_range(99)) < ena_pct);
    if (ena && rd) begin
      rd_log.push_back(addr);
      resp_addr = addr[15:0];
      resp_pend = 1'b1;
    end
    if (stall_left > 0 && out_valid && stream_q.size() == stall_idx) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = (int'($urandom_range(99)) < ready_pct);
    end
    if (out_valid && out_ready) begin
      stream_q.push_back(out_data);
      last_xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Reference: stream = optional header, then bytes from the start address up to the end pointer
  task automatic build_model();
    int e;
    int len;
    e = {mem[16'(PTR16 + 1)], mem[16'(PTR16)]};
    len = (e > START16) ? e - START16 : 0;
    exp_q.delete();
    exp_addr_q.delete();
`ifdef PRG_UPLOADER_HEADER_EN
    exp_q.push_back(8'(START16 & 255));
    exp_q.push_back(8'((START16 >> 8) & 255));
`endif
    exp_addr_q.push_back(PTR);
    exp_addr_q.push_back(PTR + 25'd1);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[16'(START16 + i)]);
      exp_addr_q.push_back(START + 25'(i));
    end
  endtask

  task automatic set_image(input int e);
    for (int i = 0; i < 64; i++) mem[16'(START16 + i)] = 8'($urandom_range(255));
    mem[16'(PTR16)]     = 8'(e & 255);
    mem[16'(PTR16 + 1)] = 8'((e >> 8) & 255);
  endtask

  task automatic kick();
    stream_q.delete();
    rd_log.delete();
    done_cnt = 0;
    last_xfer_cyc = -1;
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int timed_out);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    timed_out = (done_cnt == 0) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%0b exp=0", rd); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (addr !== 25'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
    checks++; if (out_data !== 8'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rd !== 1'b0) begin failures++; $display("FAIL idle_after_release busy=%0b rd=%0b exp=0,0", busy, rd); end
  endtask

  task automatic test_images();
    int e;
    int to;
    logic [7:0] got;
    logic [24:0] ga;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        e = START16 + 3;
        set_image(e);
        mem[16'(START16)] = 8'hAA; mem[16'(START16 + 1)] = 8'hBB; mem[16'(START16 + 2)] = 8'hCC;
        ena_pct = 100; ready_pct = 100;
      end else if (c == 1) begin
        e = START16; set_image(e); ena_pct = 100; ready_pct = 100;
      end else if (c == 2) begin
        e = 'h5600; set_image(e); ena_pct = 100; ready_pct = 100;
      end else if (c == 3) begin
        e = START16 - 1 - int'($urandom_range(300)); set_image(e); ena_pct = 60; ready_pct = 70;
      end else begin
        e = START16 + int'($urandom_range(24)); set_image(e);
        ena_pct = 30 + int'($urandom_range(70)); ready_pct = 40 + int'($urandom_range(60));
      end
      build_model();
      kick();
      wait_done(to);
      checks++; if (to != 0) begin failures++; $display("FAIL img%0d_timeout got=no_done exp=done", c); end
      checks++; if (stream_q.size() != exp_q.size()) begin failures++; $display("FAIL img%0d_len got=%0d exp=%0d", c, stream_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < stream_q.size()) ? stream_q[i] : 8'hxx;
        checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL img%0d_byte%0d got=%h exp=%h", c, i, got, exp_q[i]); end
      end
      checks++; if (rd_log.size() != exp_addr_q.size()) begin failures++; $display("FAIL img%0d_nreads got=%0d exp=%0d", c, rd_log.size(), exp_addr_q.size()); end
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        ga = (i < rd_log.size()) ? rd_log[i] : 25'hx;
        checks++; if (ga !== exp_addr_q[i]) begin failures++; $display("FAIL img%0d_addr%0d got=%h exp=%h", c, i, ga, exp_addr_q[i]); end
      end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL img%0d_done_count got=%0d exp=1", c, done_cnt); end
      if (exp_q.size() > 0) begin
        checks++; if (done_cyc != last_xfer_cyc + 1) begin failures++; $display("FAIL img%0d_done_timing got=%0d exp=%0d", c, done_cyc, last_xfer_cyc + 1); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL img%0d_busy_end got=%0b exp=0", c, busy); end
    end
  endtask

  task automatic test_stall();
    int to;
    int k;
    logic [24:0] a0;
    logic [7:0] got;
    set_image(START16 + 3);
    mem[16'(START16)] = 8'hAA; mem[16'(START16 + 1)] = 8'hBB; mem[16'(START16 + 2)] = 8'hCC;
    build_model();
    ena_pct = 100; ready_pct = 100;
`ifdef PRG_UPLOADER_HEADER_EN
    stall_idx = 3;
`else
    stall_idx = 1;
`endif
    stall_left = 20;
    kick();
    k = 0;
    while (!(out_valid === 1'b1 && out_data === 8'hBB) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    checks++; if (k >= 500) begin failures++; $display("FAIL stall_reach got=timeout exp=BB_valid"); end
    a0 = addr;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hBB || rd !== 1'b0 || addr !== a0) begin
        failures++;
        $display("FAIL stall_hold%0d got=v%0b d%h rd%0b a%h exp=v1 dBB rd0 a%h", i, out_valid, out_data, rd, addr, a0);
      end
      @(posedge clk); #1;
    end
    wait_done(to);
    stall_left = 0;
    checks++; if (to != 0 || stream_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got=%0d exp=%0d", stream_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < stream_q.size()) ? stream_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    int to;
    int k;
    logic [7:0] got;
    set_image(START16 + 6);
    build_model();
    ena_pct = 60; ready_pct = 100;
    stall_idx = 1; stall_left = 5;
    kick();
    k = 0;
    while (!(out_valid === 1'b1 && stream_q.size() == 1) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    checks++; if (k >= 500) begin failures++; $display("FAIL abort_reach got=timeout exp=second_byte"); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || rd !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear got=b%0b v%0b d%0b rd%0b exp=0000", busy, out_valid, done, rd);
    end
    stall_left = 0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++; if (stream_q.size() != 1) begin failures++; $display("FAIL abort_partial got=%0d exp=1", stream_q.size()); end
    // start and abort together in IDLE: start must win
    stream_q.delete(); rd_log.delete(); done_cnt = 0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_beats_abort got=%0b exp=1", busy); end
    wait_done(to);
    checks++; if (to != 0 || stream_q.size() != exp_q.size()) begin failures++; $display("FAIL replay_len got=%0d exp=%0d", stream_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < stream_q.size()) ? stream_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL replay_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int to;
    int k;
    logic [7:0] got;
    set_image(START16 + 10);
    build_model();
    ena_pct = 100; ready_pct = 100;
    kick();
    k = 0;
    while (!(rd === 1'b1 && addr > START + 25'd1 && addr < START + 25'd10) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    checks++; if (k >= 500) begin failures++; $display("FAIL rstmid_reach got=timeout exp=fetch"); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rd !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || addr !== 25'h0 || out_data !== 8'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=b%0b rd%0b v%0b d%0b a%h o%h exp=all_zero", busy, rd, out_valid, done, addr, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%0d busy=%0b exp=0,0", done_cnt, busy); end
    ena_pct = 50; ready_pct = 60;
    kick();
    wait_done(to);
    checks++; if (to != 0 || stream_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_len got=%0d exp=%0d", stream_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < stream_q.size()) ? stream_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [7:0] got;
    for (int r = 0; r < 3; r++) begin
      set_image(START16 + 1 + int'($urandom_range(15)));
      build_model();
      ena_pct = 40 + int'($urandom_range(60)); ready_pct = 50 + int'($urandom_range(50));
      kick();
      k = 0;
      // stray start pulses while busy must not restart or duplicate the stream
      while (done_cnt == 0 && k < 3000) begin
        @(posedge clk); #1; k++;
        start = (done_cnt == 0 && done !== 1'b1 && $urandom_range(3) == 0);
      end
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL b2b%0d_done got=%0d exp=1", r, done_cnt); end
      checks++; if (stream_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b%0d_len got=%0d exp=%0d", r, stream_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < stream_q.size()) ? stream_q[i] : 8'hxx;
        checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL b2b%0d_byte%0d got=%h exp=%h", r, i, got, exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_images();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
